// File: rtl/glitcbus_slave_if.sv
// GLITCBUS slave-side signal bundle: serial byte bus toward the TISC master
// plus the internal stb/ack register port.
interface glitcbus_slave_if;
    logic        gsel_b_i;
    logic        grdwr_b_i;
    logic [7:0]  gad_i;
    logic [7:0]  gad_o;
    logic        gad_t;
    logic [15:0] reg_adr_o;
    logic [31:0] reg_dat_o;
    logic [31:0] reg_dat_i;
    logic        reg_we_o;
    logic        reg_stb_o;
    logic        reg_ack_i;

    modport slave (
        input  gsel_b_i, grdwr_b_i, gad_i, reg_dat_i, reg_ack_i,
        output gad_o, gad_t, reg_adr_o, reg_dat_o, reg_we_o, reg_stb_o
    );

    modport master (
        output gsel_b_i, grdwr_b_i, gad_i, reg_dat_i, reg_ack_i,
        input  gad_o, gad_t, reg_adr_o, reg_dat_o, reg_we_o, reg_stb_o
    );
endinterface

// File: rtl/glitcbus_slave.sv
// GLITC-side GLITCBUS responder: turns 2 address bytes (+4 write bytes) into one
// 32-bit register access and returns read data MSB-first over GAD.
module glitcbus_slave #(
    parameter int unsigned TURNAROUND   = 2,
    parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    glitcbus_slave_if.slave bus,
    output logic            busy_o,
    output logic            timeout_o
);
    typedef enum logic [2:0] {
        IDLE, ADR_LO, WR_DAT, WR_REQ, RD_TURN, RD_DAT, WAIT_DESEL
    } state_t;

    localparam logic [2:0] TA_LAST = 3'(TURNAROUND - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_rd;
    logic [15:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        r_stb;
    logic        r_we;
    logic        r_timeout;
    logic        w_desel;

    assign w_desel = bus.gsel_b_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Deselect during any receive/turnaround/drive phase aborts; WR_REQ always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:       if (!w_desel) w_state_nxt = ADR_LO;
            ADR_LO:     if (w_desel) w_state_nxt = IDLE;
                        else         w_state_nxt = r_rd ? RD_TURN : WR_DAT;
            WR_DAT:     if (w_desel)              w_state_nxt = IDLE;
                        else if (r_cnt == 3'd3)   w_state_nxt = WR_REQ;
            WR_REQ:     if (bus.reg_ack_i) w_state_nxt = w_desel ? IDLE : WAIT_DESEL;
            RD_TURN:    if (w_desel)              w_state_nxt = IDLE;
                        else if (r_cnt == TA_LAST) w_state_nxt = RD_DAT;
            RD_DAT:     if (w_desel)              w_state_nxt = IDLE;
                        else if (r_cnt == 3'd3)   w_state_nxt = WAIT_DESEL;
            WAIT_DESEL: if (w_desel) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (r_state != IDLE);
        timeout_o     = r_timeout;
        bus.gad_t     = (r_state != RD_DAT);
        bus.gad_o     = (r_state == RD_DAT) ? r_rdat[31:24] : 8'h00;
        bus.reg_adr_o = r_adr;
        bus.reg_dat_o = r_wdat;
        bus.reg_we_o  = r_we;
        bus.reg_stb_o = r_stb;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= 3'd0;
            r_rd      <= 1'b0;
            r_adr     <= 16'h0000;
            r_wdat    <= 32'h0;
            r_rdat    <= 32'h0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (w_state_nxt == r_state) ? r_cnt + 3'd1 : 3'd0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: if (!w_desel) begin
                    r_adr[15:8] <= bus.gad_i;
                    r_rd        <= bus.grdwr_b_i;
                end
                ADR_LO: begin
                    r_adr[7:0] <= bus.gad_i;
                    if (!w_desel && r_rd) begin
                        r_stb <= 1'b1;
                        r_we  <= 1'b0;
                    end
                end
                WR_DAT: begin
                    r_wdat <= {r_wdat[23:0], bus.gad_i};
                    if (!w_desel && r_cnt == 3'd3) begin
                        r_stb <= 1'b1;
                        r_we  <= 1'b1;
                    end
                end
                WR_REQ: if (bus.reg_ack_i) begin
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
                end
                RD_TURN: begin
                    if (w_desel) begin
                        r_stb <= 1'b0;
                    end else if (r_stb && bus.reg_ack_i) begin
                        r_stb  <= 1'b0;
                        r_rdat <= bus.reg_dat_i;
                    end else if (r_stb && r_cnt == TA_LAST) begin
                        // Last chance before the master starts sampling: give up.
                        r_stb     <= 1'b0;
                        r_rdat    <= TIMEOUT_DATA;
                        r_timeout <= 1'b1;
                    end
                end
                RD_DAT:  r_rdat <= {r_rdat[23:0], 8'h00};
                default: ;
            endcase
        end
    end
endmodule
